// File: rtl/ofdm_symbol_scheduler.sv
// OFDM symbol scheduler: walks every carrier of every symbol in a frame,
// tags it as null, pilot or data, and emits one sample per carrier through
// a single-stage valid/ready output register. Data carriers pull samples
// from the mapper. Pilot carriers are BPSK values driven by a 7-bit PRBS.
module ofdm_symbol_scheduler #(
    parameter int                      N_FFT         = 1024,
    parameter int                      IDX_W         = 11,
    parameter int                      SMP_W         = 16,
    parameter int                      GUARD_LO      = 100,
    parameter int                      GUARD_HI      = 99,
    parameter int                      PILOT_SPACING = 12,
    parameter logic signed [SMP_W-1:0] PILOT_AMP     = 16'sd11585
) (
    input  logic               clk,
    input  logic               res,
    input  logic               en,
    input  logic               start,
    input  logic [7:0]         num_symbols,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [2*SMP_W-1:0] din,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [2*SMP_W-1:0] dout,
    output logic [1:0]         dout_type,
    output logic [IDX_W-1:0]   count_index,
    output logic               sop,
    output logic               eop,
    output logic               last_sym,
    output logic               busy,
    output logic               done
);

    localparam int SP_W = (PILOT_SPACING > 1) ? $clog2(PILOT_SPACING) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FFT - 1);
    localparam logic [IDX_W-1:0] IDX_LO   = IDX_W'(GUARD_LO);
    localparam logic [IDX_W-1:0] IDX_HI   = IDX_W'(N_FFT - GUARD_HI);
    localparam logic [IDX_W-1:0] IDX_DC   = IDX_W'(N_FFT / 2);
    localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(PILOT_SPACING - 1);

    localparam logic [1:0] TYPE_NULL  = 2'd0;
    localparam logic [1:0] TYPE_DATA  = 2'd1;
    localparam logic [1:0] TYPE_PILOT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [7:0]         sym_reg;
    logic [7:0]         sym_last_reg;
    logic [SP_W-1:0]    sp_reg;
    logic [6:0]         lfsr_reg;
    // Set once the final carrier of the frame has loaded; blocks further loads
    // while that beat waits for the IFFT.
    logic               tail_reg;

    logic               dout_valid_reg;
    logic [2*SMP_W-1:0] dout_reg;
    logic [1:0]         dout_type_reg;
    logic [IDX_W-1:0]   count_index_reg;
    logic               sop_reg;
    logic               eop_reg;
    logic               last_sym_reg;

    logic               is_guard;
    logic               is_null;
    logic               is_pilot;
    logic               is_data;
    logic [SP_W-1:0]    sp_eff;
    logic               load;
    logic               start_ok;
    logic [SMP_W-1:0]   pilot_i;
    logic [2*SMP_W-1:0] sample_next;
    logic [1:0]         type_next;

    // The spacing phase restarts at the first active carrier, so treat the
    // counter as zero there regardless of what the previous symbol left in it.
    assign is_guard = (idx_reg < IDX_LO) || (idx_reg >= IDX_HI);
    assign is_null  = is_guard || (idx_reg == IDX_DC);
    assign sp_eff   = (idx_reg == IDX_LO) ? '0 : sp_reg;
    assign is_pilot = !is_null && (sp_eff == '0);
    assign is_data  = !is_null && !is_pilot;

    assign start_ok = en && (state_reg == S_IDLE) && start;
    assign load     = !res && en && (state_reg == S_RUN) && !tail_reg
                      && (!dout_valid_reg || dout_ready)
                      && (!is_data || din_valid);

    assign din_ready = load && is_data;
    assign pilot_i   = lfsr_reg[6] ? -PILOT_AMP : PILOT_AMP;

    // Select the sample and tag for the carrier currently addressed by idx.
    always_comb begin
        sample_next = '0;
        type_next   = TYPE_NULL;
        if (is_data) begin
            sample_next = din;
            type_next   = TYPE_DATA;
        end else if (is_pilot) begin
            sample_next = {pilot_i, {SMP_W{1'b0}}};
            type_next   = TYPE_PILOT;
        end
    end

    // State register; en low freezes the FSM.
    always_ff @(posedge clk) begin
        if (res) begin
            state_reg <= S_IDLE;
        end else if (en) begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: the frame ends when its final eop beat is accepted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_RUN;
            S_RUN:  if (dout_valid_reg && dout_ready && eop_reg && last_sym_reg)
                        state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Carrier/symbol walk, pilot spacing phase and pilot PRBS.
    always_ff @(posedge clk) begin
        if (res) begin
            idx_reg      <= '0;
            sym_reg      <= '0;
            sym_last_reg <= '0;
            sp_reg       <= '0;
            lfsr_reg     <= 7'h7F;
            tail_reg     <= 1'b0;
        end else if (en) begin
            if (start_ok) begin
                idx_reg      <= '0;
                sym_reg      <= '0;
                sym_last_reg <= (num_symbols == 8'd0) ? 8'd0 : num_symbols - 8'd1;
                sp_reg       <= '0;
                lfsr_reg     <= 7'h7F;
                tail_reg     <= 1'b0;
            end else if (load) begin
                if (!is_guard) begin
                    sp_reg <= (sp_eff == SP_LAST) ? '0 : sp_eff + SP_W'(1);
                end
                if (is_pilot) begin
                    lfsr_reg <= {lfsr_reg[5:0], lfsr_reg[6] ^ lfsr_reg[3]};
                end
                if (idx_reg == IDX_LAST) begin
                    idx_reg <= '0;
                    if (sym_reg == sym_last_reg) begin
                        tail_reg <= 1'b1;
                    end else begin
                        sym_reg <= sym_reg + 8'd1;
                    end
                end else begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
            end
        end
    end

    // Single-stage output register; tags travel with the sample.
    always_ff @(posedge clk) begin
        if (res) begin
            dout_valid_reg  <= 1'b0;
            dout_reg        <= '0;
            dout_type_reg   <= TYPE_NULL;
            count_index_reg <= '0;
            sop_reg         <= 1'b0;
            eop_reg         <= 1'b0;
            last_sym_reg    <= 1'b0;
        end else if (en) begin
            if (load) begin
                dout_valid_reg  <= 1'b1;
                dout_reg        <= sample_next;
                dout_type_reg   <= type_next;
                count_index_reg <= idx_reg;
                sop_reg         <= (idx_reg == '0);
                eop_reg         <= (idx_reg == IDX_LAST);
                last_sym_reg    <= (sym_reg == sym_last_reg);
            end else if (dout_ready) begin
                dout_valid_reg  <= 1'b0;
            end
        end
    end

    assign dout_valid  = dout_valid_reg;
    assign dout        = dout_reg;
    assign dout_type   = dout_type_reg;
    assign count_index = count_index_reg;
    assign sop         = sop_reg;
    assign eop         = eop_reg;
    assign last_sym    = last_sym_reg;
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Bench for ofdm_symbol_scheduler in its default configuration. A
// frame-level model predicts every accepted beat from carrier arithmetic,
// the mapper samples actually consumed and a PRBS, and checks handshake
// and hold behaviour every cycle.
`timescale 1ns/1ps
module tb_ofdm_symbol_scheduler;
    localparam int N   = 1024;
    localparam int GL  = 100;
    localparam int GH  = 99;
    localparam int SP  = 12;
    localparam int PIL_PER_SYM  = 69;
    localparam int DATA_PER_SYM = 755;
    localparam logic [15:0] AMP_POS = 16'h2D41;   // +11585
    localparam logic [15:0] AMP_NEG = 16'hD2BF;   // -11585

    logic        clk = 1'b0;
    logic        res, en, start;
    logic [7:0]  num_symbols;
    logic        din_valid, din_ready;
    logic [31:0] din;
    logic        dout_valid, dout_ready;
    logic [31:0] dout;
    logic [1:0]  dout_type;
    logic [10:0] count_index;
    logic        sop, eop, last_sym, busy, done;

    always #5 clk = ~clk;

    ofdm_symbol_scheduler dut (
        .clk(clk), .res(res), .en(en), .start(start), .num_symbols(num_symbols),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .dout_type(dout_type), .count_index(count_index),
        .sop(sop), .eop(eop), .last_sym(last_sym), .busy(busy), .done(done)
    );

    int total = 0;
    int bad   = 0;

    // Model state
    bit          frame_active = 0;
    bit          done_exp = 0;
    bit          frame_done = 0;
    bit          rst_chk = 0;
    bit          hold_exp = 0;
    bit          gap_on = 0;
    logic [47:0] hold_val;
    int          beat_no = 0;
    int          nsym = 1;
    logic [6:0]  lfsr_m = 7'h7F;
    logic [31:0] cons_q[$];
    int          fr_pil = 0, fr_din = 0, fr_dat = 0;
    int          n_consumed = 0, n_presented = 0;

    // Stimulus modes
    int vmode = 0;   // 0 valid high, 1 random, 2 held low
    int rmode = 0;   // 0 ready high, 1 pattern 1,0,0,1, 2 random
    int emode = 0;   // 0 en high, 1 random
    int rcnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (beat %0d, t=%0t)", name, act, exp, beat_no, $time);
        end
    endtask

    function automatic int exp_type(input int i);
        if (i < GL || i >= N - GH || i == N / 2) return 0;
        if (((i - GL) % SP) == 0) return 2;
        return 1;
    endfunction

    // Compare process: outputs and inputs are stable at the falling edge.
    always @(negedge clk) begin
        logic [31:0] exp_smp;
        int          e_idx, e_sym, e_type;
        bit          busy_before;

        if (rst_chk) begin
            chk("reset_state", {dout_valid, din_ready, sop, eop, last_sym, busy, done,
                                dout_type, count_index, dout}, 64'd0);
            rst_chk = 0;
        end
        chk("busy", busy, frame_active || done_exp);
        chk("done", done, done_exp);
        if (!frame_active) chk("idle_valid", dout_valid, 1'b0);
        if (din_ready) chk("din_ready_cond", {din_valid, en}, 2'b11);
        if (hold_exp)
            chk("hold", {dout_valid, dout, dout_type, count_index, sop, eop, last_sym}, {1'b1, hold_val});
        if (gap_on && frame_active && beat_no > 0) chk("no_gap", dout_valid, 1'b1);

        if (res) begin
            rst_chk = 1; frame_active = 0; done_exp = 0; hold_exp = 0;
            cons_q.delete();
        end else begin
            busy_before = frame_active || done_exp;
            if (done_exp && en) done_exp = 0;
            if (din_valid && din_ready) begin
                cons_q.push_back(din);
                n_consumed++;
                fr_din++;
            end
            if (dout_valid && dout_ready && en) begin
                if (!frame_active) begin
                    total++; bad++;
                    $display("FAIL extra_beat: got beat idx %0d outside a frame, expected none", count_index);
                end else begin
                    e_idx  = beat_no % N;
                    e_sym  = beat_no / N;
                    e_type = exp_type(e_idx);
                    exp_smp = 32'd0;
                    if (e_type == 1) begin
                        fr_dat++;
                        if (cons_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL data_order: got data beat idx %0d, expected a consumed sample", e_idx);
                        end else begin
                            exp_smp = cons_q.pop_front();
                        end
                    end else if (e_type == 2) begin
                        exp_smp = {(lfsr_m[6] ? AMP_NEG : AMP_POS), 16'h0000};
                        lfsr_m  = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[3]};
                        fr_pil++;
                        if (fr_pil <= 4) chk("first_pilots", dout, {AMP_NEG, 16'h0000});
                    end
                    chk("beat", {count_index, dout_type, sop, eop, last_sym, dout},
                        {e_idx[10:0], e_type[1:0], (e_idx == 0), (e_idx == N - 1),
                         (e_sym == nsym - 1), exp_smp});
                    beat_no++;
                    if (beat_no == nsym * N) begin
                        frame_active = 0; done_exp = 1; frame_done = 1;
                        chk("pilot_count", fr_pil, PIL_PER_SYM * nsym);
                        chk("din_accepts", fr_din, DATA_PER_SYM * nsym);
                        chk("data_beats", fr_dat, DATA_PER_SYM * nsym);
                    end
                end
            end
            if (start && en && !busy_before) begin
                frame_active = 1; beat_no = 0; lfsr_m = 7'h7F;
                nsym = (num_symbols == 8'd0) ? 1 : int'(num_symbols);
                fr_pil = 0; fr_din = 0; fr_dat = 0;
            end
            hold_exp = dout_valid && !(en && dout_ready);
            hold_val = {dout, dout_type, count_index, sop, eop, last_sym};
        end
    end

    // Background driver for mapper, IFFT ready and clock enable.
    initial begin
        din = $urandom;
        forever begin
            @(posedge clk); #1;
            if (n_consumed != n_presented) begin
                din = $urandom;
                n_presented = n_consumed;
            end
            case (vmode)
                0: din_valid = 1'b1;
                1: din_valid = ($urandom_range(0, 9) < 7);
                default: din_valid = 1'b0;
            endcase
            rcnt++;
            case (rmode)
                0: dout_ready = 1'b1;
                1: dout_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
                default: dout_ready = ($urandom_range(0, 9) < 6);
            endcase
            en = (emode == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int n);
        vmode = 0; rmode = 0; emode = 0;
        cycle(); cycle();
        start = 1'b1; num_symbols = n[7:0];
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int limit, input bit mid);
        for (int c = 0; c < limit && !frame_done; c++) begin
            cycle();
            start = (mid && c == 300);
            if (mid && c == 300) num_symbols = 8'd7;
        end
        start = 1'b0;
        if (!frame_done) begin
            total++; bad++;
            $display("FAIL frame_timeout: got no final beat within %0d cycles, expected frame end", limit);
            res = 1'b1; cycle(); res = 1'b0;
        end
        vmode = 0; rmode = 0; emode = 0; gap_on = 0;
        repeat (8) cycle();
    endtask

    task automatic run_frame(input int n, input int vm, input int rm, input int em,
                             input bit g, input bit mid);
        int ns;
        ns = (n == 0) ? 1 : n;
        frame_done = 0;
        pulse_start(n);
        vmode = vm; rmode = rm; emode = em; gap_on = g;
        wait_frame(ns * N * 8 + 500, mid);
    endtask

    initial begin
        res = 1'b1; en = 1'b1; start = 1'b0; num_symbols = 8'd0;
        din_valid = 1'b0; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        cycle();

        // Two symbols at full rate: no bubbles, PRBS continues across symbols.
        run_frame(2, 0, 0, 0, 1'b1, 1'b0);
        // IFFT backpressure pattern 1,0,0,1 with a bursty mapper.
        run_frame(1, 1, 1, 0, 1'b0, 1'b0);
        // num_symbols = 0, random everything, ignored start mid-frame.
        run_frame(0, 1, 2, 1, 1'b0, 1'b1);

        // Mapper stalled from the start: frame must park at the first data carrier.
        frame_done = 0;
        pulse_start(1);
        vmode = 2;
        repeat (120) cycle();
        chk("stall_beats", beat_no, 101);
        chk("stall_drain", dout_valid, 1'b0);
        chk("stall_din_ready", din_ready, 1'b0);
        vmode = 0;
        wait_frame(N * 8, 1'b0);

        // Reset while carrier 7 of symbol 0 is pending, then a fresh frame.
        frame_done = 0;
        pulse_start(3);
        for (int c = 0; c < 100 && beat_no < 7; c++) cycle();
        chk("reset_point", count_index, 11'd7);
        res = 1'b1; cycle(); res = 1'b0;
        repeat (3) cycle();
        run_frame(1, 0, 0, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
